data_mem_sequencer: RTL and testbench

Memory-access sequencer between the execute stage and the data-memory bus.
- Turns one load/store request into bus transactions, honouring data_waitrequest.
- SB/SH are done as read-modify-write: it reads the word, hands it to the downstream byte/half merge stage, then writes back the merged word.
- Loads have their byte or half extracted and sign- or zero-extended.
- It freezes the core with core_stall until the access completes.

---
 rtl/data_mem_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_data_mem_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_sequencer.sv
// Load/store sequencer between execute and the data-memory bus: single read or
// write for LW/SW and loads, read-merge-write for SB/SH, core frozen until done.
module data_mem_sequencer #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic [5:0]        opcode,
   input  logic [ADDR_W-1:0] eff_address,
   input  logic [31:0]       rt_content,
   input  logic [31:0]       merged_writedata,
   output logic              core_stall,
   output logic              merge_stall,
   output logic [31:0]       rmw_readdata,
   output logic [1:0]        data_address2LSB,
   output logic [31:0]       load_data,
   output logic              load_valid,
   output logic              misaligned,
   output logic [ADDR_W-1:0] data_address,
   output logic              data_read,
   output logic              data_write,
   output logic [31:0]       data_writedata,
   output logic [3:0]        data_byteenable,
   input  logic              data_waitrequest,
   input  logic [31:0]       data_readdata,
   output logic [2:0]        state_o      // debug: 0 IDLE, 1 READ, 2 MERGE, 3 WRITE, 4 DONE
);
   // Bus handshake: a strobe (data_read/data_write) is held every cycle that
   // data_waitrequest is high; the transfer completes on the first cycle it is low.

   localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24,
                          OP_LHU = 6'h25, OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2b;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_READ = 3'd1, S_MERGE = 3'd2, S_WRITE = 3'd3, S_DONE = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [5:0]        op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        lsb_q, lsb_d;
   logic [31:0]       rmw_q, rmw_d, ld_q, ld_d, wd_q, wd_d;
   logic              rd_q, rd_d, wr_q, wr_d, lv_q, lv_d, mis_q, mis_d;
   logic              accept;

   function automatic logic is_mem(input logic [5:0] op);
      case (op)
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: is_mem = 1'b1;
         default: is_mem = 1'b0;
      endcase
   endfunction

   function automatic logic is_load(input logic [5:0] op);
      case (op)
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: is_load = 1'b1;
         default: is_load = 1'b0;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] lsb);
      case (op)
         OP_LH, OP_LHU, OP_SH: is_misaligned = lsb[0];
         OP_LW, OP_SW:         is_misaligned = (lsb != 2'b00);
         default:              is_misaligned = 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] extract(input logic [5:0] op, input logic [1:0] lsb,
                                           input logic [31:0] word);
      logic [31:0] shifted;
      logic [7:0]  b;
      logic [15:0] h;
      shifted = word >> {lsb, 3'b000};
      b = shifted[7:0];
      h = lsb[1] ? word[31:16] : word[15:0];
      case (op)
         OP_LB:   extract = {{24{b[7]}}, b};
         OP_LBU:  extract = {24'h0, b};
         OP_LH:   extract = {{16{h[15]}}, h};
         OP_LHU:  extract = {16'h0, h};
         default: extract = word;
      endcase
   endfunction

   assign accept = (state_q == S_IDLE) && req_valid && is_mem(opcode);

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (is_misaligned(opcode, eff_address[1:0])) state_d = S_DONE;
               else if (opcode == OP_SW)                   state_d = S_WRITE;
               else                                        state_d = S_READ;
            end
         end
         S_READ:  if (!data_waitrequest) state_d = is_load(op_q) ? S_DONE : S_MERGE;
         S_MERGE: state_d = S_WRITE;
         S_WRITE: if (!data_waitrequest) state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      core_stall  = 1'b0;
      merge_stall = 1'b1;
      case (state_q)
         S_IDLE:  core_stall = req_valid && is_mem(opcode);
         S_READ:  core_stall = 1'b1;
         S_MERGE: begin core_stall = 1'b1; merge_stall = 1'b0; end
         S_WRITE: begin core_stall = 1'b1; merge_stall = 1'b0; end
         default: core_stall = 1'b0;
      endcase
   end

   // Strobes are registered: they are raised on the edge entering READ/WRITE
   // and dropped on the edge that completes the transfer.
   always_comb begin
      op_d   = op_q;
      addr_d = addr_q;
      lsb_d  = lsb_q;
      rmw_d  = rmw_q;
      ld_d   = ld_q;
      wd_d   = wd_q;
      rd_d   = 1'b0;
      wr_d   = 1'b0;
      lv_d   = 1'b0;
      mis_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_d   = opcode;
               addr_d = {eff_address[ADDR_W-1:2], 2'b00};
               lsb_d  = eff_address[1:0];
               if (is_misaligned(opcode, eff_address[1:0])) mis_d = 1'b1;
               else if (opcode == OP_SW) begin
                  wd_d = rt_content;
                  wr_d = 1'b1;
               end else rd_d = 1'b1;
            end
         end
         S_READ: begin
            if (data_waitrequest) rd_d = 1'b1;
            else begin
               rmw_d = data_readdata;
               if (is_load(op_q)) begin
                  ld_d = extract(op_q, lsb_q, data_readdata);
                  lv_d = 1'b1;
               end
            end
         end
         S_MERGE: begin
            wd_d = merged_writedata;
            wr_d = 1'b1;
         end
         S_WRITE: wr_d = data_waitrequest;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op_q   <= 6'h0;
         addr_q <= '0;
         lsb_q  <= 2'b00;
         rmw_q  <= 32'h0;
         ld_q   <= 32'h0;
         wd_q   <= 32'h0;
         rd_q   <= 1'b0;
         wr_q   <= 1'b0;
         lv_q   <= 1'b0;
         mis_q  <= 1'b0;
      end else begin
         op_q   <= op_d;
         addr_q <= addr_d;
         lsb_q  <= lsb_d;
         rmw_q  <= rmw_d;
         ld_q   <= ld_d;
         wd_q   <= wd_d;
         rd_q   <= rd_d;
         wr_q   <= wr_d;
         lv_q   <= lv_d;
         mis_q  <= mis_d;
      end
   end

   assign rmw_readdata     = rmw_q;
   assign data_address2LSB = lsb_q;
   assign load_data        = ld_q;
   assign load_valid       = lv_q;
   assign misaligned       = mis_q;
   assign data_address     = addr_q;
   assign data_read        = rd_q;
   assign data_write       = wr_q;
   assign data_writedata   = wd_q;
   assign data_byteenable  = 4'b1111;
   assign state_o          = state_q;

endmodule

// File: tb/tb_data_mem_sequencer.sv
// Directed bench for data_mem_sequencer: per-transaction cycle timelines are built
// from the access rules and checked every cycle, plus literal spot checks.
module tb_data_mem_sequencer;

   localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24,
                          LHU = 6'h25, SB = 6'h28, SH = 6'h29, SW = 6'h2b;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic [5:0]  opcode = 6'h0;
   logic [31:0] eff_address = 32'h0;
   logic [31:0] rt_content = 32'h0;
   logic [31:0] merged_writedata = 32'h0;
   logic        data_waitrequest = 1'b0;
   logic [31:0] data_readdata = 32'h0;
   logic        core_stall, merge_stall, load_valid, misaligned, data_read, data_write;
   logic [31:0] rmw_readdata, load_data, data_address, data_writedata;
   logic [1:0]  data_address2LSB;
   logic [3:0]  data_byteenable;
   logic [2:0]  state_o;

   int total = 0;
   int bad = 0;
   logic [31:0] cur_word = 32'h0;

   typedef struct {
      logic        stall, mstall, rd, wr, lv, mis;
      logic        chk_addr; logic [31:0] addr;
      logic        chk_wd;   logic [31:0] wd;
      logic        chk_ld;   logic [31:0] ld;
      logic        chk_rmw;  logic [31:0] rmw; logic [1:0] lsb;
   } exp_t;

   exp_t exp_q[$];

   data_mem_sequencer #(.ADDR_W(32)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .opcode(opcode),
      .eff_address(eff_address), .rt_content(rt_content),
      .merged_writedata(merged_writedata), .core_stall(core_stall),
      .merge_stall(merge_stall), .rmw_readdata(rmw_readdata),
      .data_address2LSB(data_address2LSB), .load_data(load_data),
      .load_valid(load_valid), .misaligned(misaligned), .data_address(data_address),
      .data_read(data_read), .data_write(data_write), .data_writedata(data_writedata),
      .data_byteenable(data_byteenable), .data_waitrequest(data_waitrequest),
      .data_readdata(data_readdata), .state_o(state_o)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // reference rules
   function automatic logic is_load_op(input logic [5:0] op);
      return op == LB || op == LH || op == LW || op == LBU || op == LHU;
   endfunction

   function automatic logic bad_align(input logic [5:0] op, input logic [31:0] a);
      if (op == LH || op == LHU || op == SH) return a[0];
      if (op == LW || op == SW) return a[1:0] != 2'b00;
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_load(input logic [5:0] op, input logic [1:0] a,
                                              input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(w >> (8 * a));
      h = a[1] ? w[31:16] : w[15:0];
      case (op)
         LB:      return 32'($signed(b));
         LBU:     return 32'(b);
         LH:      return 32'($signed(h));
         LHU:     return 32'(h);
         default: return w;
      endcase
   endfunction

   function automatic exp_t quiet();
      exp_t e;
      e = '{stall: 1'b0, mstall: 1'b1, rd: 1'b0, wr: 1'b0, lv: 1'b0, mis: 1'b0,
            chk_addr: 1'b0, addr: 32'h0, chk_wd: 1'b0, wd: 32'h0,
            chk_ld: 1'b0, ld: 32'h0, chk_rmw: 1'b0, rmw: 32'h0, lsb: 2'b00};
      return e;
   endfunction

   // driver: apply one cycle of inputs at negedge and queue what the cycle must show
   task automatic cyc(input logic rv, input logic wq, input logic rst, input exp_t e);
      @(negedge clk);
      req_valid        = rv;
      data_waitrequest = wq;
      reset            = rst;
      data_readdata    = wq ? 32'hBAD0BAD0 : cur_word;
      exp_q.push_back(e);
   endtask

   task automatic run(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                      input logic [31:0] word, input logic [31:0] merged, input int w);
      exp_t e;
      logic [31:0] waddr;
      waddr = {addr[31:2], 2'b00};
      opcode = op; eff_address = addr; rt_content = rt;
      cur_word = word; merged_writedata = merged;
      e = quiet(); e.stall = 1'b1;
      cyc(1'b1, 1'b0, 1'b0, e);
      if (bad_align(op, addr)) begin
         e = quiet(); e.mis = 1'b1;
         cyc(1'b1, 1'b0, 1'b0, e);
      end else begin
         if (op != SW) begin
            for (int i = 0; i <= w; i++) begin
               e = quiet(); e.stall = 1'b1; e.rd = 1'b1; e.chk_addr = 1'b1; e.addr = waddr;
               cyc(1'b1, i < w, 1'b0, e);
            end
            if (!is_load_op(op)) begin
               e = quiet(); e.stall = 1'b1; e.mstall = 1'b0;
               e.chk_rmw = 1'b1; e.rmw = word; e.lsb = addr[1:0];
               cyc(1'b1, 1'b0, 1'b0, e);
            end
         end
         if (!is_load_op(op)) begin
            for (int i = 0; i <= w; i++) begin
               e = quiet(); e.stall = 1'b1; e.mstall = 1'b0; e.wr = 1'b1;
               e.chk_addr = 1'b1; e.addr = waddr;
               e.chk_wd = 1'b1; e.wd = (op == SW) ? rt : merged;
               cyc(1'b1, i < w, 1'b0, e);
               merged_writedata = 32'h0BADF00D;
            end
         end
         e = quiet();
         if (is_load_op(op)) begin
            e.lv = 1'b1; e.chk_ld = 1'b1; e.ld = model_load(op, addr[1:0], word);
         end
         cyc(1'b1, 1'b0, 1'b0, e);
      end
      e = quiet();
      cyc(1'b0, 1'b0, 1'b0, e);
   endtask

   // compare process: every queued cycle is checked 2 time units after negedge
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("core_stall", 32'(core_stall), 32'(e.stall));
            chk("merge_stall", 32'(merge_stall), 32'(e.mstall));
            chk("data_read", 32'(data_read), 32'(e.rd));
            chk("data_write", 32'(data_write), 32'(e.wr));
            chk("load_valid", 32'(load_valid), 32'(e.lv));
            chk("misaligned", 32'(misaligned), 32'(e.mis));
            chk("byteenable", 32'(data_byteenable), 32'hF);
            if (e.chk_addr) chk("data_address", data_address, e.addr);
            if (e.chk_wd)   chk("data_writedata", data_writedata, e.wd);
            if (e.chk_ld)   chk("load_data", load_data, e.ld);
            if (e.chk_rmw) begin
               chk("rmw_readdata", rmw_readdata, e.rmw);
               chk("addr2lsb", 32'(data_address2LSB), 32'(e.lsb));
            end
         end
      end
   end

   initial begin
      exp_t e;
      repeat (3) @(negedge clk);
      e = quiet();
      e.chk_addr = 1'b1; e.chk_wd = 1'b1; e.chk_ld = 1'b1; e.chk_rmw = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, e);
      #3 chk("reset_state", 32'(state_o), 32'd0);

      run(LW, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 0);
      #3 chk("pin_lw", load_data, 32'hDEADBEEF);
      run(LB, 32'h103, 32'h0, 32'h80112233, 32'h0, 0);
      #3 chk("pin_lb", load_data, 32'hFFFFFF80);
      run(LBU, 32'h103, 32'h0, 32'h80112233, 32'h0, 0);
      #3 chk("pin_lbu", load_data, 32'h00000080);
      run(LH, 32'h102, 32'h0, 32'h80112233, 32'h0, 0);
      #3 chk("pin_lh", load_data, 32'hFFFF8011);
      run(LHU, 32'h102, 32'h0, 32'h80112233, 32'h0, 0);
      #3 chk("pin_lhu", load_data, 32'h00008011);
      run(SB, 32'h201, 32'h000000AB, 32'h11223344, 32'h1122AB44, 0);
      #3 begin
         chk("pin_sb_wd", data_writedata, 32'h1122AB44);
         chk("pin_sb_rmw", rmw_readdata, 32'h11223344);
         chk("pin_sb_lsb", 32'(data_address2LSB), 32'd1);
         chk("pin_sb_addr", data_address, 32'h200);
      end
      run(SW, 32'h300, 32'hCAFEF00D, 32'h0, 32'h0, 3);
      #3 chk("pin_sw_wd", data_writedata, 32'hCAFEF00D);
      run(LW, 32'h102, 32'h0, 32'h12345678, 32'h0, 0);
      run(SH, 32'h101, 32'h1234, 32'h0, 32'h0, 0);
      run(LHU, 32'h203, 32'h0, 32'h0, 32'h0, 0);
      run(SH, 32'h402, 32'h0000BEEF, 32'hA5A55A5A, 32'hBEEF5A5A, 2);
      run(LB, 32'h500, 32'h0, 32'h7F7F7F45, 32'h0, 1);
      run(LH, 32'h600, 32'h0, 32'h00009234, 32'h0, 2);
      run(LW, 32'h704, 32'h0, 32'h0BB0C0DE, 32'h0, 2);

      // non-memory opcodes are ignored
      opcode = 6'h00; eff_address = 32'h103;
      e = quiet();
      cyc(1'b1, 1'b0, 1'b0, e);
      opcode = 6'h22;
      cyc(1'b1, 1'b0, 1'b0, e);
      cyc(1'b0, 1'b0, 1'b0, e);
      #3 chk("nonmem_idle", 32'(state_o), 32'd0);

      // reset asserted mid-READ
      opcode = LW; eff_address = 32'h800; cur_word = 32'h55555555;
      e = quiet(); e.stall = 1'b1;
      cyc(1'b1, 1'b0, 1'b0, e);
      e = quiet(); e.stall = 1'b1; e.rd = 1'b1; e.chk_addr = 1'b1; e.addr = 32'h800;
      cyc(1'b1, 1'b1, 1'b0, e);
      cyc(1'b1, 1'b1, 1'b1, e);
      e = quiet(); e.chk_addr = 1'b1; e.chk_ld = 1'b1; e.chk_wd = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, e);
      #3 chk("reset_mid_read_state", 32'(state_o), 32'd0);
      e = quiet();
      cyc(1'b0, 1'b0, 1'b0, e);

      repeat (2) @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
